// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and branch flush control for a 5-stage MIPS-style pipeline.
// Tracks whether the instruction now in ID/EX is a load and which register it writes.
// The ID-stage instruction stalls one cycle when it reads that register.
// A taken branch in EX flushes IF/ID. A flush wins over a stall in the same cycle.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   id_valid         - IF/ID holds a real instruction
//   id_opcode/rs/rt  - fields of the instruction in ID
//   ex_branch_taken  - BEQ in EX resolved taken this cycle
//   hazard_detected  - zero ID/EX control fields (combinational)
//   pc_write         - PC load enable (combinational)
//   ifid_write       - IF/ID load enable (combinational)
//   ifid_flush       - clear IF/ID to a NOP (combinational)
//   state            - registered FSM state: RUN=00, STALL=01, FLUSH=10
//   stall_cnt        - saturating count of load-use stall cycles
//   flush_cnt        - saturating count of branch flush cycles
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_branch_taken,
  output logic             hazard_detected,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             ex_load_q, ex_load_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic uses_rs, uses_rt;
  logic load_use, flush;

  // Source-register usage decode
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_BEQ, OP_SW: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_LW:   uses_rs = 1'b1;
      default: ;
    endcase
  end

  // Hazard conditions, controls, and next-state logic
  always_comb begin
    // ex_load_q is already cleared during reset; gating flush with rst_n forces the idle controls
    load_use = id_valid & ex_load_q & (ex_rt_q != 5'd0) &
               ((uses_rs & (id_rs == ex_rt_q)) | (uses_rt & (id_rt == ex_rt_q)));
    flush    = rst_n & ex_branch_taken;

    hazard_detected = 1'b0;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    state_d         = ST_RUN;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;

    if (flush) begin
      hazard_detected = 1'b1;
      ifid_flush      = 1'b1;
      state_d         = ST_FLUSH;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (load_use) begin
      hazard_detected = 1'b1;
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      state_d         = ST_STALL;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // The injected bubble never carries a load, so a stall lasts exactly one cycle
    ex_load_d = id_valid & (id_opcode == OP_LW) & ~hazard_detected;
    ex_rt_d   = id_rt;
  end

  // State and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ex_load_q   <= 1'b0;
      ex_rt_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_load_q   <= ex_load_d;
      ex_rt_q     <= ex_rt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: drives two hazard_unit instances (CNT_W=16 and CNT_W=2) with the same
// stimulus and checks them against an instruction-level reference model.
module tb_hazard_unit;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_BQ = 6'b000100;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       ex_branch_taken = 1'b0;

  logic        hd16, pcw16, ifw16, iff16;
  logic [1:0]  st16;
  logic [15:0] sc16, fc16;
  logic        hd2, pcw2, ifw2, iff2;
  logic [1:0]  st2;
  logic [1:0]  sc2, fc2;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: whether the previous accepted ID instruction was a load, and its target
  bit prev_load;
  int prev_dst;
  int m_state;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_unit u_dut16 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ex_branch_taken(ex_branch_taken),
    .hazard_detected(hd16), .pc_write(pcw16), .ifid_write(ifw16), .ifid_flush(iff16),
    .state(st16), .stall_cnt(sc16), .flush_cnt(fc16)
  );

  hazard_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ex_branch_taken(ex_branch_taken),
    .hazard_detected(hd2), .pc_write(pcw2), .ifid_write(ifw2), .ifid_flush(iff2),
    .state(st2), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    prev_load = 1'b0;
    prev_dst  = 0;
    m_state   = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic check_regs(input string nm);
    cmp_cnt++;
    if (st16 !== 2'(m_state) || st2 !== 2'(m_state)) begin
      err_cnt++;
      $display("FAIL %s state: got %0d/%0d want %0d", nm, st16, st2, m_state);
    end
    cmp_cnt++;
    if (sc16 !== 16'(sat(m_stall, 65535)) || sc2 !== 2'(sat(m_stall, 3))) begin
      err_cnt++;
      $display("FAIL %s stall_cnt: got %0d/%0d want %0d/%0d", nm, sc16, sc2,
               sat(m_stall, 65535), sat(m_stall, 3));
    end
    cmp_cnt++;
    if (fc16 !== 16'(sat(m_flush, 65535)) || fc2 !== 2'(sat(m_flush, 3))) begin
      err_cnt++;
      $display("FAIL %s flush_cnt: got %0d/%0d want %0d/%0d", nm, fc16, fc2,
               sat(m_flush, 65535), sat(m_flush, 3));
    end
  endtask

  task automatic check_ctrl(input string nm, input logic [3:0] exp);
    cmp_cnt++;
    if ({hd16, pcw16, ifw16, iff16} !== exp || {hd2, pcw2, ifw2, iff2} !== exp) begin
      err_cnt++;
      $display("FAIL %s ctrl{hd,pcw,ifw,iff}: got %b/%b want %b", nm,
               {hd16, pcw16, ifw16, iff16}, {hd2, pcw2, ifw2, iff2}, exp);
    end
  endtask

  // One pipeline cycle: apply ID instruction, check controls, clock, check registers
  task automatic cycle(input string nm, input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br);
    bit reads_rs, reads_rt, lu, fl;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; ex_branch_taken = br;
    #1;
    reads_rs = (op == OP_R) || (op == OP_BQ) || (op == OP_SW) || (op == OP_LW);
    reads_rt = (op == OP_R) || (op == OP_BQ) || (op == OP_SW);
    lu = v && prev_load && prev_dst != 0 &&
         ((reads_rs && int'(rs) == prev_dst) || (reads_rt && int'(rt) == prev_dst));
    fl = br;
    if (fl)      check_ctrl(nm, 4'b1111);
    else if (lu) check_ctrl(nm, 4'b1000);
    else         check_ctrl(nm, 4'b0110);
    @(posedge clk);
    m_state   = fl ? 2 : (lu ? 1 : 0);
    if (fl)      m_flush++;
    else if (lu) m_stall++;
    prev_load = v && op == OP_LW && !fl && !lu;
    prev_dst  = int'(rt);
    #1;
    check_regs(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    id_valid = 1'b1; id_opcode = OP_R; id_rs = 5'd1; id_rt = 5'd1; ex_branch_taken = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_ctrl("reset_forced", 4'b0110);
    check_regs("reset_regs");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use_rtype();
    do_reset();
    cycle("lu_lw", 1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    cycle("lu_stall", 1'b1, OP_R, 5'd5, 5'd7, 1'b0);
    cmp_cnt++;
    if (st16 !== 2'b01 || sc16 !== 16'd1) begin
      err_cnt++;
      $display("FAIL lu_stall_const: state %0d cnt %0d want 1/1", st16, sc16);
    end
    cycle("lu_held", 1'b1, OP_R, 5'd5, 5'd7, 1'b0);
    cmp_cnt++;
    if (st16 !== 2'b00 || sc16 !== 16'd1) begin
      err_cnt++;
      $display("FAIL lu_one_cycle: state %0d cnt %0d want 0/1", st16, sc16);
    end
  endtask

  task automatic test_sw_lw();
    do_reset();
    cycle("sw_lw", 1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
    cycle("sw_stall", 1'b1, OP_SW, 5'd2, 5'd5, 1'b0);
    cycle("sw_held", 1'b1, OP_SW, 5'd2, 5'd5, 1'b0);
    cycle("lw_lw", 1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
    cycle("lw_nostall", 1'b1, OP_LW, 5'd3, 5'd5, 1'b0);
    cmp_cnt++;
    if (sc16 !== 16'd1) begin
      err_cnt++;
      $display("FAIL sw_lw_cnt: got %0d want 1", sc16);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    cycle("zero_lw", 1'b1, OP_LW, 5'd4, 5'd0, 1'b0);
    cycle("zero_use", 1'b1, OP_R, 5'd0, 5'd0, 1'b0);
    cmp_cnt++;
    if (sc16 !== 16'd0 || hd16 !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_reg: cnt %0d hd %0b want 0/0", sc16, hd16);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    cycle("fp_lw", 1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    cycle("fp_both", 1'b1, OP_R, 5'd5, 5'd7, 1'b1);
    cmp_cnt++;
    if (st16 !== 2'b10 || fc16 !== 16'd1 || sc16 !== 16'd0) begin
      err_cnt++;
      $display("FAIL flush_prio: state %0d fcnt %0d scnt %0d want 2/1/0", st16, fc16, sc16);
    end
    cycle("fp_after", 1'b1, OP_R, 5'd5, 5'd7, 1'b0);
  endtask

  task automatic test_saturation();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle("sat_lw", 1'b1, OP_LW, 5'd5, 5'd5, 1'b0);
      cycle("sat_use", 1'b1, OP_R, 5'd5, 5'd6, 1'b0);
      cmp_cnt++;
      if (sc2 !== want[i]) begin
        err_cnt++;
        $display("FAIL sat_seq[%0d]: got %0d want %0d", i, sc2, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cycle("rms_lw", 1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    cycle("rms_stall", 1'b1, OP_R, 5'd5, 5'd7, 1'b0);
    cycle("rms_lw2", 1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    id_valid = 1'b1; id_opcode = OP_R; id_rs = 5'd5; id_rt = 5'd7; ex_branch_taken = 1'b0;
    #1;
    check_ctrl("rms_pre", 4'b1000);
    @(posedge clk); #1;
    ex_branch_taken = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ctrl("rms_forced", 4'b0110);
    check_regs("rms_async");
    @(negedge clk);
    rst_n = 1'b1;
    // First cycle after reset cannot stall even though rs matches the old load target
    cycle("rms_first", 1'b1, OP_R, 5'd5, 5'd5, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] op;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_BQ;
        2: op = OP_SW;
        3, 4: op = OP_LW;
        default: op = 6'($urandom);
      endcase
      cycle("rand", 1'($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use_rtype();
    test_sw_lw();
    test_zero_reg();
    test_flush_priority();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
